// File: rtl/mem_stage.sv
// Memory-access stage: serialises B/H/W loads and stores over an 8-bit handshaked
// port, stalling upstream until the access completes, then hands the write-back triple on.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] memaddr_i,
   input  logic        memwr_i,
   input  logic [1:0]  memcnf_i,
   input  logic        memsigned_i,
   output logic        mem_req_o,
   output logic        mem_wr_o,
   output logic [31:0] mem_addr_o,
   output logic [7:0]  mem_dout_o,
   input  logic        mem_ack_i,
   input  logic [7:0]  mem_din_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        mem_stall_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_cnt;
   logic [4:0]  r_wd;
   logic        r_wreg;
   logic [31:0] r_wdata;
   logic [31:0] r_addr;
   logic        r_memwr;
   logic [1:0]  r_memcnf;
   logic        r_signed;
   logic [31:0] r_buf;

   logic [1:0]  w_last;
   logic        w_capture;
   logic        w_ack_busy;
   logic [31:0] w_load_val;

   // Index of the final byte: N-1 for N = 1, 2, 4.
   assign w_last     = (r_memcnf == 2'd3) ? 2'd3 : (r_memcnf == 2'd2) ? 2'd1 : 2'd0;
   assign w_capture  = (r_state == IDLE) && (memcnf_i != 2'd0);
   assign w_ack_busy = (r_state == BUSY) && mem_ack_i;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (memcnf_i != 2'd0) w_state_next = BUSY;
         BUSY:    if (mem_ack_i && (r_cnt == w_last)) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_wd     <= 5'd0;
         r_wreg   <= 1'b0;
         r_wdata  <= 32'd0;
         r_addr   <= 32'd0;
         r_memwr  <= 1'b0;
         r_memcnf <= 2'd0;
         r_signed <= 1'b0;
         r_buf    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_capture) begin
            r_cnt    <= 2'd0;
            r_wd     <= wd_i;
            r_wreg   <= wreg_i;
            r_wdata  <= wdata_i;
            r_addr   <= memaddr_i;
            r_memwr  <= memwr_i;
            r_memcnf <= memcnf_i;
            r_signed <= memsigned_i;
            r_buf    <= 32'd0;
         end
         if (w_ack_busy) begin
            if (!r_memwr) r_buf[{r_cnt, 3'b000} +: 8] <= mem_din_i;
            if (r_cnt != w_last) r_cnt <= r_cnt + 2'd1;
         end
      end
   end

   always_comb begin
      case (r_memcnf)
         2'd1:    w_load_val = {{24{r_signed & r_buf[7]}}, r_buf[7:0]};
         2'd2:    w_load_val = {{16{r_signed & r_buf[15]}}, r_buf[15:0]};
         default: w_load_val = r_buf;
      endcase
   end

   // Everything is forced low while reset is held, including the IDLE pass-through.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_wr_o    = 1'b0;
      mem_addr_o  = 32'd0;
      mem_dout_o  = 8'd0;
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      mem_stall_o = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE: begin
               if (memcnf_i == 2'd0) begin
                  wd_o    = wd_i;
                  wreg_o  = wreg_i;
                  wdata_o = wdata_i;
               end else begin
                  mem_stall_o = 1'b1;
               end
            end
            BUSY: begin
               mem_req_o   = 1'b1;
               mem_wr_o    = r_memwr;
               mem_addr_o  = r_addr + {30'd0, r_cnt};
               mem_dout_o  = r_wdata[{r_cnt, 3'b000} +: 8];
               mem_stall_o = 1'b1;
            end
            DONE: begin
               wd_o    = r_wd;
               wreg_o  = r_wreg;
               wdata_o = r_memwr ? r_wdata : w_load_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-memory responder with programmable ack delays,
// a write-back monitor, and a reference model computing load/store results from byte memory.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] memaddr_i;
   logic        memwr_i;
   logic [1:0]  memcnf_i;
   logic        memsigned_i;
   logic        mem_req_o;
   logic        mem_wr_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_dout_o;
   logic        mem_ack_i = 1'b0;
   logic [7:0]  mem_din_i = 8'd0;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        mem_stall_o;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .memaddr_i(memaddr_i),
      .memwr_i(memwr_i), .memcnf_i(memcnf_i), .memsigned_i(memsigned_i),
      .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
      .mem_dout_o(mem_dout_o), .mem_ack_i(mem_ack_i), .mem_din_i(mem_din_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .mem_stall_o(mem_stall_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  dout;
      int          wait_cyc;
   } req_t;

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
   } res_t;

   req_t req_q[$];
   res_t res_q[$];
   logic [7:0] ref_mem [logic [31:0]];
   logic [7:0] dev_mem [logic [31:0]];

   int n_tests = 0;
   int n_fail  = 0;
   bit suspend   = 1'b0;
   bit op_active = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event not expected at %0t", name, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'd0, mem_stall_o}, 32'd0);
      check({tag, "_req"},   {31'd0, mem_req_o},   32'd0);
      check({tag, "_wr"},    {31'd0, mem_wr_o},    32'd0);
      check({tag, "_addr"},  mem_addr_o,           32'd0);
      check({tag, "_dout"},  {24'd0, mem_dout_o},  32'd0);
      check({tag, "_wd"},    {27'd0, wd_o},        32'd0);
      check({tag, "_wreg"},  {31'd0, wreg_o},      32'd0);
      check({tag, "_wdata"}, wdata_o,              32'd0);
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ref_mem[a] = b;
      dev_mem[a] = b;
   endtask

   // Memory responder: checks each byte request and acks after its programmed delay.
   req_t cur;
   bit   have_cur = 1'b0;
   int   wleft = 0;
   always @(negedge clk) begin
      if (rst) begin
         mem_ack_i = 1'b0;
         have_cur  = 1'b0;
      end else if (suspend) begin
         mem_ack_i = 1'b1;
         mem_din_i = 8'($urandom);
         have_cur  = 1'b0;
      end else if (mem_req_o) begin
         if (!have_cur) begin
            if (req_q.size() == 0) begin
               fail_now("unexpected_req");
               mem_ack_i = 1'b0;
            end else begin
               cur = req_q.pop_front();
               have_cur = 1'b1;
               wleft = cur.wait_cyc;
            end
         end
         if (have_cur) begin
            check("req_addr", mem_addr_o, cur.addr);
            check("req_wr", {31'd0, mem_wr_o}, {31'd0, cur.wr});
            check("req_dout", {24'd0, mem_dout_o}, {24'd0, cur.dout});
            if (wleft > 0) begin
               wleft--;
               mem_ack_i = 1'b0;
               mem_din_i = 8'($urandom);
            end else begin
               mem_ack_i = 1'b1;
               if (cur.wr) dev_mem[cur.addr] = mem_dout_o;
               else mem_din_i = dev_mem.exists(cur.addr) ? dev_mem[cur.addr] : 8'h00;
               have_cur = 1'b0;
            end
         end
      end else begin
         check("noreq_addr", mem_addr_o, 32'd0);
         check("noreq_dout", {24'd0, mem_dout_o}, 32'd0);
         mem_ack_i = 1'($urandom_range(0, 1));
         mem_din_i = 8'($urandom);
      end
   end

   // Write-back monitor: pops the expected triple when the stage stops stalling.
   res_t got_exp;
   always @(negedge clk) begin
      if (op_active && !rst && !suspend) begin
         if (mem_stall_o) begin
            check("stall_wreg", {31'd0, wreg_o}, 32'd0);
         end else if (res_q.size() == 0) begin
            fail_now("unexpected_result");
         end else begin
            got_exp = res_q.pop_front();
            check("wb_wd", {27'd0, wd_o}, {27'd0, got_exp.wd});
            check("wb_wreg", {31'd0, wreg_o}, {31'd0, got_exp.wreg});
            check("wb_wdata", wdata_o, got_exp.wdata);
         end
      end
   end

   // Issue one op, push its expected bytes/result, then hold it until the stall drops.
   task automatic do_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] addr, input logic wr, input logic [1:0] cnf,
                        input logic sgn, input int wmode);
      int          n;
      int          exp_stall;
      int          stalls;
      bit          done;
      logic [63:0] val;
      logic [31:0] a;
      logic [7:0]  bv;
      req_t        q;
      res_t        r;
      n = (cnf == 2'd3) ? 4 : int'(cnf);
      r.wd = wd;
      r.wreg = wreg;
      r.wdata = wdata;
      exp_stall = 0;
      val = 64'd0;
      if (cnf != 2'd0) begin
         exp_stall = 1;
         for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            bv = 8'((wdata >> (8 * k)) & 32'hFF);
            q.addr = a;
            q.wr = wr;
            q.dout = bv;
            q.wait_cyc = (wmode >= 0) ? wmode : int'($urandom_range(0, 2));
            exp_stall += 1 + q.wait_cyc;
            if (wr) begin
               ref_mem[a] = bv;
            end else begin
               if (!ref_mem.exists(a)) preload(a, 8'($urandom));
               val = val | (64'(ref_mem[a]) << (8 * k));
            end
            req_q.push_back(q);
         end
         if (!wr) begin
            if (sgn && val[8 * n - 1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
            r.wdata = val[31:0];
         end
      end
      res_q.push_back(r);
      wd_i = wd;
      wreg_i = wreg;
      wdata_i = wdata;
      memaddr_i = addr;
      memwr_i = wr;
      memcnf_i = cnf;
      memsigned_i = sgn;
      op_active = 1'b1;
      stalls = 0;
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (mem_stall_o) stalls++;
         else done = 1'b1;
      end
      if (!done) fail_now("stall_timeout");
      else check("stall_cycles", 32'(stalls), 32'(exp_stall));
      $display("[TB] op cnf=%0d wr=%0d addr=%h wdata_in=%h -> wdata_o=%h stalls=%0d",
               cnf, wr, addr, wdata, wdata_o, stalls);
      @(posedge clk);
      #1;
      op_active = 1'b0;
      memcnf_i = 2'd0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D; memaddr_i = 32'h40;
      memwr_i = 1'b0; memcnf_i = 2'd0; memsigned_i = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases
      do_op(5'd5, 1'b1, 32'h0000_1234, 32'h0, 1'b0, 2'd0, 1'b0, 0);
      preload(32'h100, 8'h80);
      do_op(5'd3, 1'b1, 32'h0, 32'h100, 1'b0, 2'd1, 1'b1, 0);
      preload(32'h201, 8'h34);
      preload(32'h202, 8'h12);
      do_op(5'd9, 1'b1, 32'h0, 32'h201, 1'b0, 2'd2, 1'b0, 2);
      do_op(5'd0, 1'b0, 32'hDEAD_BEEF, 32'h1000, 1'b1, 2'd3, 1'b0, 0);
      do_op(5'd12, 1'b1, 32'h0, 32'h1000, 1'b0, 2'd3, 1'b0, 1);
      preload(32'hFFFF_FFFE, 8'h11);
      preload(32'hFFFF_FFFF, 8'h22);
      preload(32'h0000_0000, 8'h33);
      preload(32'h0000_0001, 8'h44);
      do_op(5'd15, 1'b1, 32'h0, 32'hFFFF_FFFE, 1'b0, 2'd3, 1'b0, 0);

      // Reset in the middle of an LW, on its third byte
      suspend = 1'b1;
      wd_i = 5'd21; wreg_i = 1'b1; wdata_i = 32'h0; memaddr_i = 32'h300;
      memwr_i = 1'b0; memcnf_i = 2'd3; memsigned_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_third_addr", mem_addr_o, 32'h302);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      memcnf_i = 2'd0; wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA;
      #1;
      check_all_zero("rst_passthru");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      suspend = 1'b0;
      req_q.delete();
      res_q.delete();
      @(posedge clk);
      #1;
      preload(32'h10, 8'h5A);
      do_op(5'd6, 1'b1, 32'h0, 32'h10, 1'b0, 2'd1, 1'b1, 0);

      // Randomized back-to-back traffic
      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : 32'h400 + 32'($urandom_range(0, 31));
         do_op(5'($urandom), 1'($urandom), $urandom, ra, 1'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom), -1);
      end

      check("req_q_drained", 32'(req_q.size()), 32'd0);
      check("res_q_drained", 32'(res_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
